// File: rtl/display_scheduler.sv
// display_scheduler: selects the 7-segment page and RAM-viewer word, with auto/manual rotation after halt.
module display_scheduler #(
  parameter int TICK_DIV       = 100_000,
  parameter int DWELL_TICKS    = 2000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int RAM_WORDS      = 32,
  parameter int ADDR_W         = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_halt,
  input  logic              btn_next,
  input  logic              btn_auto,
  output logic [2:0]        display_op,
  output logic [ADDR_W-1:0] ram_display_addr,
  output logic              auto_mode,
  output logic              tick
);
  typedef enum logic [2:0] {
    PROG   = 3'b000,
    TOTAL  = 3'b001,
    UNCOND = 3'b011,
    COND   = 3'b111,
    BUBBLE = 3'b101,
    RAM    = 3'b010
  } state_t;
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam int BW = $clog2(DEBOUNCE_TICKS + 1);
  logic [TW-1:0]     div_cnt;
  logic [1:0]        s1, s2, press;
  logic [DW-1:0]     dwell, dwell_n;
  logic [ADDR_W-1:0] addr_n;
  state_t            state, state_n;
  logic              auto_n, run, adv;
  assign tick = div_cnt == TW'(TICK_DIV - 1);
  assign display_op = state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt <= '0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      s1 <= {btn_auto, btn_next};
      s2 <= s1;
    end
  // bit 0 = next, bit 1 = auto; a press fires in the same clk the debounced level rises
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [BW-1:0] cnt;
    logic          lvl, fire;
    assign fire = tick && (s2[b] != lvl) && cnt == BW'(DEBOUNCE_TICKS - 1);
    assign press[b] = fire & s2[b];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (tick) begin
        cnt <= (s2[b] == lvl || fire) ? '0 : cnt + 1'b1;
        lvl <= fire ? s2[b] : lvl;
      end
  end
  always_comb begin
    run = state != PROG && cpu_halt;
    adv = run && (press[0] || (auto_mode && tick && dwell == DW'(DWELL_TICKS - 1)));
    auto_n = auto_mode ^ (run && press[1]);
    state_n = state;
    addr_n = ram_display_addr;
    dwell_n = dwell;
    if (state == PROG || !cpu_halt) begin
      state_n = cpu_halt ? TOTAL : PROG;
      addr_n = '0;
      dwell_n = '0;
    end else if (adv) begin
      dwell_n = '0;
      addr_n = state == RAM ? ram_display_addr + 1'b1 : ram_display_addr;
      state_n = state == TOTAL  ? UNCOND :
                state == UNCOND ? COND   :
                state == COND   ? BUBBLE :
                state == BUBBLE ? RAM    :
                ram_display_addr == ADDR_W'(RAM_WORDS - 1) ? TOTAL : RAM;
    end else if (press[1]) begin
      dwell_n = '0;
    end else if (auto_mode && tick) begin
      dwell_n = dwell + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= PROG;
      ram_display_addr <= '0;
      dwell <= '0;
      auto_mode <= 1'b1;
    end else begin
      state <= state_n;
      ram_display_addr <= addr_n;
      dwell <= dwell_n;
      auto_mode <= auto_n;
    end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of page rotation, buttons, halt and reset behaviour.
module tb_display_scheduler;
  logic       clk = 0, rst = 1, cpu_halt = 0, btn_next = 0, btn_auto = 0;
  logic [2:0] display_op;
  logic [1:0] ram_display_addr;
  logic       auto_mode, tick;
  int         total = 0, bad = 0, n, ticks;
  display_scheduler #(
    .TICK_DIV(4), .DWELL_TICKS(3), .DEBOUNCE_TICKS(2), .RAM_WORDS(4), .ADDR_W(2)
  ) dut (
    .clk(clk), .rst(rst), .cpu_halt(cpu_halt), .btn_next(btn_next), .btn_auto(btn_auto),
    .display_op(display_op), .ram_display_addr(ram_display_addr),
    .auto_mode(auto_mode), .tick(tick)
  );
  always #5 clk = ~clk;
  // view = {display_op, ram_display_addr}
  function automatic int view();
    return int'({display_op, ram_display_addr});
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_chg(output int cyc);
    int s;
    s = view();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (view() == s && cyc < 60);
    if (view() == s) cyc = -1;
  endtask
  task automatic expect_chg(input string tag, input int cyc, input int val);
    int c;
    wait_chg(c);
    chk({tag, "_cyc"}, c, cyc);
    chk({tag, "_val"}, view(), val);
  endtask
  initial begin
    step(3);
    chk("rst_op", int'(display_op), 0);
    chk("rst_addr", int'(ram_display_addr), 0);
    chk("rst_auto", int'(auto_mode), 1);
    chk("rst_tick", int'(tick), 0);
    rst = 0;
    ticks = 0;
    repeat (48) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    chk("t1_ticks", ticks, 12);
    chk("t1_view", view(), 0);
    chk("t1_auto", int'(auto_mode), 1);
    n = 0;
    while (!tick && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("t2_align", int'(tick), 1);
    cpu_halt = 1;
    step(1);
    chk("t2_total", view(), 'b00100);
    expect_chg("t2_uncond", 12, 'b01100);
    expect_chg("t2_cond",   12, 'b11100);
    expect_chg("t2_bubble", 12, 'b10100);
    expect_chg("t2_ram0",   12, 'b01000);
    expect_chg("t2_ram1",   12, 'b01001);
    expect_chg("t2_ram2",   12, 'b01010);
    expect_chg("t2_ram3",   12, 'b01011);
    expect_chg("t2_wrap",   12, 'b00100);
    btn_auto = 1;
    step(12);
    btn_auto = 0;
    chk("t3_manual", int'(auto_mode), 0);
    chk("t3_hold0", view(), 'b00100);
    step(40);
    chk("t3_idle", view(), 'b00100);
    btn_next = 1;
    step(12);
    btn_next = 0;
    step(20);
    chk("t3_press", view(), 'b01100);
    btn_next = 1;
    step(4);
    btn_next = 0;
    step(20);
    chk("t3_glitch", view(), 'b01100);
    btn_auto = 1;
    n = 0;
    while (!auto_mode && n < 40) begin
      @(negedge clk);
      n++;
    end
    btn_auto = 0;
    chk("t4_auto", int'(auto_mode), 1);
    step(4);
    btn_next = 1;
    expect_chg("t4_coinc", 8, 'b11100);
    btn_next = 0;
    expect_chg("t4_dwell0", 12, 'b10100);
    expect_chg("t5_ram0", 12, 'b01000);
    expect_chg("t5_ram1", 12, 'b01001);
    expect_chg("t5_ram2", 12, 'b01010);
    step(11);
    chk("t5_tick", int'(tick), 1);
    cpu_halt = 0;
    step(1);
    chk("t5_prog", view(), 0);
    cpu_halt = 1;
    expect_chg("t6_total", 1, 'b00100);
    expect_chg("t6_uncond", 11, 'b01100);
    expect_chg("t6_cond", 12, 'b11100);
    btn_next = 1;
    step(1);
    #2 rst = 1;
    #1;
    chk("t6_rst_op", int'(display_op), 0);
    chk("t6_rst_auto", int'(auto_mode), 1);
    chk("t6_rst_addr", int'(ram_display_addr), 0);
    chk("t6_rst_tick", int'(tick), 0);
    @(negedge clk);
    rst = 0;
    step(1);
    chk("t6_total2", view(), 'b00100);
    expect_chg("t6_press", 7, 'b01100);
    btn_next = 0;
    expect_chg("t6_single", 12, 'b11100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequences the 7-segment display datapath by driving its 3-bit page select (display_op) and the RAM-viewer word address.
- While the CPU runs, the program output page is shown.
- After halt, the block rotates through the statistics pages and RAM words. Rotation is automatic on a dwell timer or manual via a debounced push-button.
- Sits between board buttons / CPU status and the display block.

Parameters:
TICK_DIV, 100_000, clk cycles per internal 1 kHz tick (minimum 2)
DWELL_TICKS, 2000, ticks each page or RAM word is held in auto mode (minimum 1)
DEBOUNCE_TICKS, 20, ticks a raw button level must stay stable before it is accepted (minimum 1)
RAM_WORDS, 32, number of RAM words stepped on the RAM page (power of 2, at least 2)
ADDR_W, 5, width of ram_display_addr, equal to log2(RAM_WORDS)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
cpu_halt  input  1  level; 1 = program finished (syscall 10 reached)
btn_next  input  1  raw asynchronous push-button: advance page or word
btn_auto  input  1  raw asynchronous push-button: toggle auto/manual
display_op  output  3  page select to display block
ram_display_addr  output  ADDR_W  word index for RAM viewer
auto_mode  output  1  1 = timed rotation active
tick  output  1  one-clk pulse per internal tick (observability)

Behaviour:
- Clocking and reset
  - Single clk domain. All state is reset asynchronously by rst=1.
  - Reset values: display_op=000, ram_display_addr=0, auto_mode=1, tick=0, all counters 0, FSM=PROG, debounced button levels 0.
- Tick generator
  - Prescale counter runs 0..TICK_DIV-1.
  - tick=1 for exactly the one clk in which the counter wraps.
- Button inputs
  - Each button is passed through a 2-FF synchroniser.
  - The debounced level updates only when the synchronised level has differed from it for DEBOUNCE_TICKS consecutive ticks.
  - A press event is a one-clk pulse on a 0->1 edge of the debounced level. Releases generate no event.
- auto_mode
  - Toggles on each btn_auto press event.
  - A toggle clears the dwell counter.
- FSM states and their display_op encoding:
  - PROG = 000
  - TOTAL = 001
  - UNCOND = 011
  - COND = 111
  - BUBBLE = 101
  - RAM = 010
  - display_op is registered: it changes on the clk after the causing event (1-cycle latency). No other encoding is ever output.
- Transitions
  - PROG: held while cpu_halt=0. On cpu_halt=1, go to TOTAL with ram_display_addr=0 and the dwell counter cleared.
  - Advance event:
    - In manual mode, a btn_next press.
    - In auto mode, the dwell counter reaching DWELL_TICKS-1 on a tick, or a btn_next press.
  - Stats ring order: TOTAL -> UNCOND -> COND -> BUBBLE -> RAM.
  - In RAM, an advance increments ram_display_addr. From address RAM_WORDS-1, an advance sets the address to 0 and moves to TOTAL.
  - In any non-PROG state, cpu_halt=0 forces PROG on the next clk. ram_display_addr and the dwell counter are cleared, and all pending events are discarded.
- Dwell counter
  - Increments on tick, in auto mode, in non-PROG states only.
  - Cleared on every advance, on every state change, and on every auto_mode toggle.
- Simultaneous events
  - A btn_next press coinciding with dwell expiry produces exactly one advance.
  - cpu_halt falling in the same clk as an advance: PROG wins.
  - btn_auto and btn_next press events in the same clk: the toggle applies and the advance still happens. The dwell counter ends at 0.
  - Events while in PROG (except cpu_halt rising) are ignored.
- Reset mid-operation returns immediately to the reset values. There is no residual press event after release of rst, even if a button is held: the debounced level starts at 0, so a held button yields exactly one press event after DEBOUNCE_TICKS.

Test Plan:
Parameters for all benches: TICK_DIV=4, DWELL_TICKS=3, DEBOUNCE_TICKS=2, RAM_WORDS=4, ADDR_W=2.
1. Reset with cpu_halt=0 for 50 clk -> display_op stays 000, auto_mode=1, ram_display_addr=0, tick pulses every 4 clk.
2. Raise cpu_halt, auto mode -> display_op=001 one clk later, then 011, 111, 101, 010 each after 3 ticks (12 clk). ram_display_addr steps 0,1,2,3 then wraps to 0 with display_op=001.
3. Toggle to manual (btn_auto held 3 ticks), then 40 clk idle -> display_op unchanged. One btn_next press (held 3 ticks) -> exactly one advance. A 1-tick glitch on btn_next -> no advance.
4. Auto mode: assert a btn_next press event in the same clk as dwell expiry -> exactly one page advance, and the dwell counter reads 0 afterwards.
5. In RAM with addr=2, drop cpu_halt in the same clk as an advance -> next clk display_op=000, ram_display_addr=0.
6. Assert rst mid-rotation (display_op=111) while btn_next is held -> display_op=000 and auto_mode=1 immediately (asynchronous). After rst release with cpu_halt=1: one clk later FSM=TOTAL (display_op=001); the held btn_next then yields a single press event after 2 ticks, advancing display_op to 011.
